// File: rtl/physics_pkg.sv
// Shared types and screen constants for the player motion engine.
package physics_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_DEAD   = 2'd2,
    ST_WIN    = 2'd3
  } state_e;

  localparam int PLAYER_W     = 16;
  localparam int PLAYER_H     = 16;
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;
  localparam int X_MAX        = 623;
  localparam int Y_MAX        = 463;
  localparam int LAVA_Y       = 380;

  // Clamp a signed 11-bit coordinate into [0, hi].
  function automatic logic [9:0] clamp_coord(input logic signed [10:0] v,
                                             input logic [9:0] hi);
    logic [9:0] r;
    if (v < 11'sd0) begin
      r = 10'd0;
    end else if (v > $signed({1'b0, hi})) begin
      r = hi;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/player_physics.sv
// Per-frame player motion engine: position, vertical velocity and GROUND/AIR/DEAD/WIN FSM.
// Optional feature: define VARIABLE_JUMP_EN to cut the upward arc when jump is released early.
module player_physics
  import physics_pkg::*;
#(
  parameter int START_X      = 20,
  parameter int START_Y      = 344,
  parameter int RUN_SPEED    = 2,
  parameter int JUMP_VEL     = 9,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL     = 8,
  parameter int DEATH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       on_ground,
  input  logic [9:0] support_y,
  input  logic       hit_ceiling,
  input  logic       hit_left_wall,
  input  logic       hit_right_wall,
  input  logic       at_goal_region,
  input  logic       in_lava,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [5:0] vel_y,
  output logic [1:0] state,
  output logic       death_pulse,
  output logic       win
);

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [5:0] vel_q, vel_d;
  logic              jump_prev_q, jump_prev_d;
  logic [5:0]        death_cnt_q, death_cnt_d;
  logic              death_pulse_q, death_pulse_d;
  logic              win_q, win_d;

  logic               jump_press, death_done, step_under;
  logic signed [5:0]  vel_eff, step_vel_in, step_vel;
  logic signed [10:0] dx, y_sum, vel_sum;
  logic [9:0]         x_move, step_y, land_y;

  // Candidate horizontal move, vertical step and landing height for this tick.
  always_comb begin
    jump_press = btn_jump & ~jump_prev_q;
    death_done = (death_cnt_q == 6'(DEATH_FRAMES - 1));
`ifdef VARIABLE_JUMP_EN
    vel_eff = (!btn_jump && (vel_q < -6'sd2)) ? -6'sd2 : vel_q;
`else
    vel_eff = vel_q;
`endif
    // From GROUND the only vertical step taken is the jump launch.
    step_vel_in = (state_q == ST_GROUND) ? -$signed(6'(JUMP_VEL)) : vel_eff;
    y_sum       = $signed({1'b0, y_q}) + 11'(step_vel_in);
    vel_sum     = 11'(step_vel_in) + 11'(GRAVITY);
    step_vel    = (vel_sum > 11'(MAX_FALL)) ? 6'(MAX_FALL) : vel_sum[5:0];
    step_under  = (y_sum < 11'sd0);
    step_y      = clamp_coord(y_sum, 10'(Y_MAX));
    land_y      = clamp_coord($signed({1'b0, support_y}) - 11'(PLAYER_H), 10'(Y_MAX));
    if (btn_right && !btn_left && !hit_right_wall) begin
      dx = 11'(RUN_SPEED);
    end else if (btn_left && !btn_right && !hit_left_wall) begin
      dx = -11'(RUN_SPEED);
    end else begin
      dx = 11'sd0;
    end
    x_move = clamp_coord($signed({1'b0, x_q}) + dx, 10'(X_MAX));
  end

  // Next-state logic of the movement FSM.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        ST_GROUND: begin
          if (in_lava)                       state_d = ST_DEAD;
          else if (at_goal_region)           state_d = ST_WIN;
          else if (jump_press || !on_ground) state_d = ST_AIR;
          else                               state_d = ST_GROUND;
        end
        ST_AIR: begin
          if (in_lava)                       state_d = ST_DEAD;
          else if (on_ground && !vel_q[5])   state_d = ST_GROUND;
          else                               state_d = ST_AIR;
        end
        ST_DEAD: state_d = death_done ? ST_AIR : ST_DEAD;
        ST_WIN:  state_d = ST_WIN;
        default: state_d = ST_AIR;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and output updates for the current state.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    vel_d         = vel_q;
    jump_prev_d   = jump_prev_q;
    death_cnt_d   = death_cnt_q;
    death_pulse_d = 1'b0;
    win_d         = (state_d == ST_WIN);
    if (frame_tick) begin
      jump_prev_d = btn_jump;
      case (state_q)
        ST_GROUND, ST_AIR: begin
          if (in_lava) begin
            death_pulse_d = 1'b1;
            death_cnt_d   = 6'd0;
          end else if (state_q == ST_GROUND && at_goal_region) begin
            x_d = x_q;
          end else begin
            x_d = x_move;
            if (state_q == ST_GROUND && !jump_press && !on_ground) begin
              vel_d = 6'sd0;
            end else if ((state_q == ST_GROUND && !jump_press) ||
                         (state_q == ST_AIR && on_ground && !vel_q[5])) begin
              y_d   = land_y;
              vel_d = 6'sd0;
            end else if (state_q == ST_AIR && hit_ceiling && vel_eff[5]) begin
              vel_d = 6'sd0;
            end else begin
              y_d   = step_y;
              vel_d = step_under ? 6'sd0 : step_vel;
            end
          end
        end
        ST_DEAD: begin
          if (death_done) begin
            death_cnt_d = 6'd0;
            x_d         = 10'(START_X);
            y_d         = 10'(START_Y);
            vel_d       = 6'sd0;
          end else begin
            death_cnt_d = death_cnt_q + 6'd1;
          end
        end
        ST_WIN:  x_d = x_q;
        default: x_d = x_q;
      endcase
    end else begin
      jump_prev_d = jump_prev_q;
    end
  end

  // State register with asynchronous reset to the spawn point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_AIR;
      x_q           <= 10'(START_X);
      y_q           <= 10'(START_Y);
      vel_q         <= 6'sd0;
      jump_prev_q   <= 1'b0;
      death_cnt_q   <= 6'd0;
      death_pulse_q <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vel_q         <= vel_d;
      jump_prev_q   <= jump_prev_d;
      death_cnt_q   <= death_cnt_d;
      death_pulse_q <= death_pulse_d;
      win_q         <= win_d;
    end
  end

  assign player_x    = x_q;
  assign player_y    = y_q;
  assign vel_y       = vel_q;
  assign state       = state_q;
  assign death_pulse = death_pulse_q;
  assign win         = win_q;

endmodule

// File: tb/tb_player_physics.sv
// Directed self-checking bench for player_physics with hand-computed expectations.
module tb_player_physics;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic       on_ground = 1'b0;
  logic [9:0] support_y = 10'd360;
  logic       hit_ceiling = 1'b0, hit_left_wall = 1'b0, hit_right_wall = 1'b0;
  logic       at_goal_region = 1'b0, in_lava = 1'b0;
  logic [9:0] player_x, player_y;
  logic [5:0] vel_y;
  logic [1:0] state;
  logic       death_pulse, win;

  int checks = 0;
  int errors = 0;

  player_physics dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .on_ground(on_ground), .support_y(support_y),
    .hit_ceiling(hit_ceiling), .hit_left_wall(hit_left_wall), .hit_right_wall(hit_right_wall),
    .at_goal_region(at_goal_region), .in_lava(in_lava),
    .player_x(player_x), .player_y(player_y), .vel_y(vel_y),
    .state(state), .death_pulse(death_pulse), .win(win)
  );

  always #5 clk = ~clk;

  // n back-to-back ticks; returns at a negedge with outputs settled
  task automatic ticks(input int n);
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic clear_inputs();
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    on_ground = 1'b0; support_y = 10'd360;
    hit_ceiling = 1'b0; hit_left_wall = 1'b0; hit_right_wall = 1'b0;
    at_goal_region = 1'b0; in_lava = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic land_at_360();
    on_ground = 1'b1; support_y = 10'd360;
    ticks(1);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({player_x, player_y, vel_y, state, death_pulse, win} !== {10'd20, 10'd344, 6'd0, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got x=%0d y=%0d v=%0d st=%0d dp=%0b win=%0b, want 20/344/0/1/0/0",
               player_x, player_y, $signed(vel_y), state, death_pulse, win);
    end
    rst = 1'b0;
  endtask

  task automatic test_fall_clamp();
    reset_dut();
    ticks(8);
    checks++;
    if ({state, player_y, vel_y} !== {2'd1, 10'd372, 6'd8}) begin
      errors++;
      $display("FAIL fall8: got st=%0d y=%0d v=%0d, want 1/372/8", state, player_y, $signed(vel_y));
    end
    ticks(12);
    checks++;
    if ({player_y, vel_y} !== {10'd463, 6'd8}) begin
      errors++;
      $display("FAIL fall_clamp: got y=%0d v=%0d, want 463/8", player_y, $signed(vel_y));
    end
    ticks(5);
    checks++;
    if ({state, player_y, vel_y} !== {2'd1, 10'd463, 6'd8}) begin
      errors++;
      $display("FAIL fall_hold: got st=%0d y=%0d v=%0d, want 1/463/8", state, player_y, $signed(vel_y));
    end
  endtask

  task automatic test_jump_arc();
    reset_dut();
    land_at_360();
    checks++;
    if ({state, player_y, vel_y} !== {2'd0, 10'd344, 6'd0}) begin
      errors++;
      $display("FAIL land: got st=%0d y=%0d v=%0d, want 0/344/0", state, player_y, $signed(vel_y));
    end
    btn_jump = 1'b1; on_ground = 1'b0;
    ticks(1);
    checks++;
    if ({state, player_y, vel_y} !== {2'd1, 10'd335, 6'h38}) begin
      errors++;
      $display("FAIL jump: got st=%0d y=%0d v=%0d, want 1/335/-8", state, player_y, $signed(vel_y));
    end
    ticks(1);
    checks++;
    if ({player_y, vel_y} !== {10'd327, 6'h39}) begin
      errors++;
      $display("FAIL jump2: got y=%0d v=%0d, want 327/-7", player_y, $signed(vel_y));
    end
    ticks(2);
    checks++;
    if ({player_y, vel_y} !== {10'd314, 6'h3B}) begin
      errors++;
      $display("FAIL jump4: got y=%0d v=%0d, want 314/-5", player_y, $signed(vel_y));
    end
    hit_ceiling = 1'b1;
    ticks(1);
    hit_ceiling = 1'b0;
    checks++;
    if ({state, player_y, vel_y} !== {2'd1, 10'd314, 6'd0}) begin
      errors++;
      $display("FAIL ceiling: got st=%0d y=%0d v=%0d, want 1/314/0", state, player_y, $signed(vel_y));
    end
    ticks(10);
    checks++;
    if ({player_y, vel_y} !== {10'd358, 6'd8}) begin
      errors++;
      $display("FAIL max_fall: got y=%0d v=%0d, want 358/8", player_y, $signed(vel_y));
    end
    on_ground = 1'b1;
    ticks(1);
    checks++;
    if ({state, player_y, vel_y} !== {2'd0, 10'd344, 6'd0}) begin
      errors++;
      $display("FAIL reland: got st=%0d y=%0d v=%0d, want 0/344/0", state, player_y, $signed(vel_y));
    end
    ticks(2);
    checks++;
    if ({state, player_y} !== {2'd0, 10'd344}) begin
      errors++;
      $display("FAIL held_jump: got st=%0d y=%0d, want 0/344", state, player_y);
    end
    btn_jump = 1'b0;
  endtask

  task automatic test_run();
    btn_right = 1'b1;
    ticks(40);
    checks++;
    if (player_x !== 10'd100) begin
      errors++;
      $display("FAIL run40: got x=%0d, want 100", player_x);
    end
    ticks(3);
    checks++;
    if (player_x !== 10'd106) begin
      errors++;
      $display("FAIL run3: got x=%0d, want 106", player_x);
    end
    hit_right_wall = 1'b1;
    ticks(1);
    hit_right_wall = 1'b0;
    checks++;
    if (player_x !== 10'd106) begin
      errors++;
      $display("FAIL right_wall: got x=%0d, want 106", player_x);
    end
    btn_left = 1'b1;
    ticks(1);
    checks++;
    if (player_x !== 10'd106) begin
      errors++;
      $display("FAIL both_btn: got x=%0d, want 106", player_x);
    end
    btn_right = 1'b0;
    ticks(1);
    checks++;
    if (player_x !== 10'd104) begin
      errors++;
      $display("FAIL run_left: got x=%0d, want 104", player_x);
    end
    hit_left_wall = 1'b1;
    ticks(1);
    hit_left_wall = 1'b0;
    checks++;
    if (player_x !== 10'd104) begin
      errors++;
      $display("FAIL left_wall: got x=%0d, want 104", player_x);
    end
    ticks(60);
    checks++;
    if ({state, player_x} !== {2'd0, 10'd0}) begin
      errors++;
      $display("FAIL left_clamp: got st=%0d x=%0d, want 0/0", state, player_x);
    end
    btn_left = 1'b0;
  endtask

  task automatic test_top_clamp();
    on_ground = 1'b1; support_y = 10'd20;
    ticks(1);
    checks++;
    if ({state, player_y} !== {2'd0, 10'd4}) begin
      errors++;
      $display("FAIL high_land: got st=%0d y=%0d, want 0/4", state, player_y);
    end
    btn_jump = 1'b1; on_ground = 1'b0;
    ticks(1);
    btn_jump = 1'b0;
    checks++;
    if ({state, player_y, vel_y} !== {2'd1, 10'd0, 6'd0}) begin
      errors++;
      $display("FAIL top_clamp: got st=%0d y=%0d v=%0d, want 1/0/0", state, player_y, $signed(vel_y));
    end
  endtask

  task automatic test_death();
    reset_dut();
    land_at_360();
    btn_right = 1'b1;
    ticks(2);
    btn_right = 1'b0;
    in_lava = 1'b1;
    ticks(1);
    in_lava = 1'b0;
    checks++;
    if ({state, death_pulse, player_x} !== {2'd2, 1'b1, 10'd24}) begin
      errors++;
      $display("FAIL enter_dead: got st=%0d dp=%0b x=%0d, want 2/1/24", state, death_pulse, player_x);
    end
    @(negedge clk);
    checks++;
    if (death_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: got dp=%0b, want 0", death_pulse);
    end
    btn_right = 1'b1; btn_jump = 1'b1;
    ticks(59);
    checks++;
    if ({state, player_x, player_y, death_pulse} !== {2'd2, 10'd24, 10'd344, 1'b0}) begin
      errors++;
      $display("FAIL dead59: got st=%0d x=%0d y=%0d dp=%0b, want 2/24/344/0", state, player_x, player_y, death_pulse);
    end
    btn_right = 1'b0; btn_jump = 1'b0;
    ticks(1);
    checks++;
    if ({state, player_x, player_y, vel_y} !== {2'd1, 10'd20, 10'd344, 6'd0}) begin
      errors++;
      $display("FAIL respawn: got st=%0d x=%0d y=%0d v=%0d, want 1/20/344/0", state, player_x, player_y, $signed(vel_y));
    end
    // second death interrupted by reset
    land_at_360();
    btn_right = 1'b1;
    ticks(2);
    btn_right = 1'b0;
    in_lava = 1'b1;
    ticks(1);
    in_lava = 1'b0;
    ticks(30);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state, player_x, player_y, death_pulse, win} !== {2'd1, 10'd20, 10'd344, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_death_rst: got st=%0d x=%0d y=%0d dp=%0b win=%0b, want 1/20/344/0/0",
               state, player_x, player_y, death_pulse, win);
    end
    @(negedge clk);
    rst = 1'b0;
    land_at_360();
    in_lava = 1'b1;
    ticks(1);
    in_lava = 1'b0;
    ticks(59);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL cnt_cleared: got st=%0d, want 2", state);
    end
    ticks(1);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL respawn2: got st=%0d, want 1", state);
    end
  endtask

  task automatic test_win();
    reset_dut();
    land_at_360();
    at_goal_region = 1'b1;
    ticks(1);
    checks++;
    if ({state, win, player_x, player_y} !== {2'd3, 1'b1, 10'd20, 10'd344}) begin
      errors++;
      $display("FAIL win: got st=%0d win=%0b x=%0d y=%0d, want 3/1/20/344", state, win, player_x, player_y);
    end
    btn_right = 1'b1; btn_jump = 1'b1; in_lava = 1'b1; on_ground = 1'b0;
    ticks(3);
    checks++;
    if ({state, win, player_x, player_y, vel_y, death_pulse} !== {2'd3, 1'b1, 10'd20, 10'd344, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL win_frozen: got st=%0d win=%0b x=%0d y=%0d v=%0d dp=%0b, want 3/1/20/344/0/0",
               state, win, player_x, player_y, $signed(vel_y), death_pulse);
    end
    clear_inputs();
  endtask

  task automatic test_jump_release();
    reset_dut();
    land_at_360();
    btn_jump = 1'b1; on_ground = 1'b0;
    ticks(1);
    checks++;
    if ({player_y, vel_y} !== {10'd335, 6'h38}) begin
      errors++;
      $display("FAIL rel_jump: got y=%0d v=%0d, want 335/-8", player_y, $signed(vel_y));
    end
    btn_jump = 1'b0;
    ticks(1);
`ifdef VARIABLE_JUMP_EN
    checks++;
    if ({player_y, vel_y} !== {10'd333, 6'h3F}) begin
      errors++;
      $display("FAIL var_jump: got y=%0d v=%0d, want 333/-1", player_y, $signed(vel_y));
    end
`else
    checks++;
    if ({player_y, vel_y} !== {10'd327, 6'h39}) begin
      errors++;
      $display("FAIL full_arc: got y=%0d v=%0d, want 327/-7", player_y, $signed(vel_y));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fall_clamp();
    test_jump_arc();
    test_run();
    test_top_clamp();
    test_death();
    test_win();
    test_jump_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
